// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-only register file. Synchronises the SPI pins into the clk
// domain, shifts in 16-bit frames (W/R, addr[6:0], data[7:0], MSB first) and
// commits well-formed writes into five 8-bit control registers.
module spi_reg_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,      // synchroniser depth, must be >= 2
  parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic [6:0] wr_addr
);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_hist_q, ncs_hist_q;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_fall, ncs_rise;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic        commit;

  logic [7:0]  reg0_q, reg1_q, reg2_q, reg3_q, reg4_q;
  logic        wr_strobe_q;
  logic [6:0]  wr_addr_q;

  // Pin synchronisers plus one history flop each for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_hist_q <= 1'b0;
      ncs_hist_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_hist_q <= sclk_s;
      ncs_hist_q  <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign ncs_fall  = ~ncs_s & ncs_hist_q;
  assign ncs_rise  = ncs_s & ~ncs_hist_q;

  // FSM, bit counter and shift register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state: a same-cycle sclk_rise and ncs_rise both land on this edge,
  // so COMMIT sees the counter including that final bit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    commit  = 1'b0;
    case (state_q)
      StIdle: begin
        if (ncs_fall) begin
          cnt_d   = '0;
          shreg_d = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (sclk_rise) begin
          shreg_d = {shreg_q[14:0], copi_s};
          // Saturate at 17 so over-long frames stay distinguishable from 16
          if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
        end
        if (ncs_rise) state_d = StCommit;
      end
      StCommit: begin
        commit  = (cnt_q == 5'd16) && shreg_q[15] && (shreg_q[14:8] <= MAX_ADDR);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Register file update and registered write strobe / address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg0_q      <= '0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      reg3_q      <= '0;
      reg4_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      wr_strobe_q <= commit;
      if (commit) begin
        wr_addr_q <= shreg_q[14:8];
        case (shreg_q[14:8])
          7'd0:    reg0_q <= shreg_q[7:0];
          7'd1:    reg1_q <= shreg_q[7:0];
          7'd2:    reg2_q <= shreg_q[7:0];
          7'd3:    reg3_q <= shreg_q[7:0];
          7'd4:    reg4_q <= shreg_q[7:0];
          default: ;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = reg0_q;
  assign en_reg_out_15_8 = reg1_q;
  assign en_reg_pwm_7_0  = reg2_q;
  assign en_reg_pwm_15_8 = reg3_q;
  assign pwm_duty_cycle  = reg4_q;
  assign wr_strobe       = wr_strobe_q;
  assign wr_addr         = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Scoreboard bench for spi_reg_peripheral: the driver pushes the expected
// commit for each valid write frame; a monitor pops one entry per wr_strobe.
module tb_spi_reg_peripheral;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       wr_strobe;
  logic [6:0] wr_addr;

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         pushes = 0;
  int         strobes_seen = 0;
  logic [7:0] model_regs [5];
  logic [6:0] model_wr_addr;

  spi_reg_peripheral dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (r0),
    .en_reg_out_15_8 (r1),
    .en_reg_pwm_7_0  (r2),
    .en_reg_pwm_15_8 (r3),
    .pwm_duty_cycle  (r4),
    .wr_strobe       (wr_strobe),
    .wr_addr         (wr_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] get_reg(input int a);
    case (a)
      0:       return r0;
      1:       return r1;
      2:       return r2;
      3:       return r3;
      default: return r4;
    endcase
  endfunction

  // Monitor: every strobe must match the oldest outstanding expected write
  always @(negedge clk) begin
    if (rst_n && wr_strobe) begin
      strobes_seen++;
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", {25'd0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("strobe_addr", {25'd0, wr_addr}, {25'd0, e.addr});
        check("strobe_data", {24'd0, get_reg(int'(e.addr))}, {24'd0, e.data});
        check("strobe_latency", cyc, e.due);
      end
    end
  end

  task automatic check_all(input string tag);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s_reg%0d", tag, i), {24'd0, get_reg(i)}, {24'd0, model_regs[i]});
    end
    check({tag, "_wr_addr"}, {25'd0, wr_addr}, {25'd0, model_wr_addr});
  endtask

  // Sends n bits MSB first; sclk = clk/10, copi changes on the falling edge
  task automatic drive_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = val[i];
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  // Full frame from a negedge; wr marks a frame that must commit
  task automatic frame(input logic [31:0] val, input int n, input bit wr, input int gap);
    ncs = 1'b0;
    repeat (6) @(negedge clk);
    drive_bits(val, n);
    repeat (5) @(negedge clk);
    ncs = 1'b1;
    if (wr) begin
      exp_t e;
      e.addr = val[14:8];
      e.data = val[7:0];
      e.due  = cyc + 4;
      sb_q.push_back(e);
      pushes++;
      model_regs[int'(val[14:8])] = val[7:0];
      model_wr_addr = val[14:8];
    end
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 5; i++) model_regs[i] = 8'h00;
    model_wr_addr = 7'd0;

    // Reset
    repeat (5) @(negedge clk);
    check_all("in_reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_all("post_reset");
    check("post_reset_strobe", {31'd0, wr_strobe}, 32'd0);

    // Valid writes to every address
    frame(32'h80F0, 16, 1'b1, 10);
    frame(32'h81CC, 16, 1'b1, 10);
    frame(32'h8255, 16, 1'b1, 10);
    frame(32'h83AA, 16, 1'b1, 10);
    frame(32'h8480, 16, 1'b1, 10);
    check_all("valid");

    // Rejected: read frame, address just past MAX_ADDR, top address
    frame(32'h00FF, 16, 1'b0, 10);
    frame(32'h85FF, 16, 1'b0, 10);
    frame(32'hFF11, 16, 1'b0, 10);
    check_all("rejected");

    // Short and long frames aimed at duty cycle, then the correct one
    frame(32'h4219, 15, 1'b0, 10);          // first 15 bits of 0x8433
    check_all("short15");
    frame(32'h10866, 17, 1'b0, 10);         // 0x8433 followed by an extra 0
    check_all("long17");
    frame(32'h8433, 16, 1'b1, 10);
    check_all("fixed16");

    // Reset in the middle of 0x8177, frame completed after release
    ncs = 1'b0;
    repeat (6) @(negedge clk);
    drive_bits(32'h81, 8);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) model_regs[i] = 8'h00;
    model_wr_addr = 7'd0;
    repeat (3) @(negedge clk);
    check_all("mid_reset");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    drive_bits(32'h77, 8);
    repeat (5) @(negedge clk);
    ncs = 1'b1;
    repeat (10) @(negedge clk);
    check_all("after_partial");
    frame(32'h8177, 16, 1'b1, 10);
    check_all("refill");

    // Back-to-back with the minimum ncs high gap
    frame(32'h8401, 16, 1'b1, 4);
    frame(32'h84FE, 16, 1'b1, 12);
    check_all("b2b");

    check("outstanding_expected", sb_q.size(), 32'd0);
    check("strobe_count", strobes_seen, pushes);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_peripheral.md
Name: spi_reg_peripheral

Overview:
- SPI (mode 0) write-only register-file peripheral inside tt_um_uwasic_onboarding_judy_yu; sits directly upstream of the PWM/output stage.
- Receives 16-bit frames on ui_in pins (sclk, copi, ncs) and decodes them into five 8-bit control registers: output enables, PWM enables and PWM duty cycle.
- The downstream PWM stage consumes those registers.
- All SPI pins are asynchronous to clk and are synchronised inside the block.

Parameters:
SYNC_STAGES  2  flip-flop depth of the input synchronisers for sclk, copi and ncs (minimum 2)
MAX_ADDR  7'h04  highest valid register address; writes above it are dropped

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
sclk  input  1  SPI clock, asynchronous
copi  input  1  SPI data from controller, asynchronous
ncs  input  1  SPI chip select, active-low, asynchronous
en_reg_out_7_0  output  8  address 0x00: uo_out output enables
en_reg_out_15_8  output  8  address 0x01: uio_out output enables
en_reg_pwm_7_0  output  8  address 0x02: PWM select for uo_out
en_reg_pwm_15_8  output  8  address 0x03: PWM select for uio_out
pwm_duty_cycle  output  8  address 0x04: duty, 0x00 = 0 %, 0xFF = 100 %
wr_strobe  output  1  one-cycle pulse when any register is committed
wr_addr  output  7  address of the last committed write; holds between writes

Behaviour:
- Reset (rst_n low, asynchronous):
  - All five registers = 0x00; wr_strobe = 0; wr_addr = 0; bit counter = 0; shift register = 0; FSM = IDLE.
  - Synchroniser flops reset to sclk = 0, copi = 0, ncs = 1.
- Synchronisation and edge detection:
  - Each pin passes through SYNC_STAGES flops, plus one history flop for edge detection.
  - sclk_rise = synced sclk 0->1. ncs_fall = synced ncs 1->0. ncs_rise = synced ncs 0->1.
- Frame format, MSB first, 16 bits:
  - bit 15 = R/W (1 = write).
  - bits 14:8 = address.
  - bits 7:0 = data.
- FSM states IDLE, SHIFT, COMMIT:
  - IDLE: on ncs_fall, clear counter and shift register, go to SHIFT. Ignore sclk.
  - SHIFT: on each sclk_rise, shift synced copi into the LSB and increment the counter, which saturates at 17.
    - On ncs_rise go to COMMIT.
    - ncs_fall is impossible in this state.
  - COMMIT (exactly one cycle): write only if all hold: counter == 16, R/W == 1, address <= MAX_ADDR.
    - On a write: the addressed register takes the data, wr_strobe = 1 for this cycle, wr_addr = address.
    - Otherwise nothing changes and wr_strobe stays 0.
    - Always return to IDLE.
- Frame rejection:
  - Frames with fewer than 16 or more than 16 sclk_rise edges are discarded whole.
  - No partial writes.
  - Read frames (bit 15 = 0) are discarded; there is no read-back path.
- Latency: a new register value is visible on the clk edge SYNC_STAGES+2 cycles after the ncs pin rises (4 cycles at default), the same edge on which wr_strobe asserts.
- sclk_rise coinciding with ncs_rise: the bit is shifted first, then the transition to COMMIT is evaluated on the updated counter.
- Timing constraint on the environment: sclk high and low phases >= SYNC_STAGES+1 clk periods each; ncs high time between frames >= SYNC_STAGES+2 clk periods. Behaviour outside these limits is undefined but must never leave the FSM outside IDLE/SHIFT/COMMIT.
- Reset mid-frame:
  - Clears everything immediately.
  - If ncs is still low when reset releases, the synchroniser produces ncs_fall and the remainder of the frame is captured. That frame has fewer than 16 bits, so it is discarded.
- Registers hold their value indefinitely between writes. A rewrite with the same value still pulses wr_strobe.

Test Plan:
- Reset check: rst_n low 5 cycles then high, no SPI activity -> all five registers 0x00, wr_strobe never asserted, wr_addr 0.
- Valid writes: frames 0x80F0, 0x81CC, 0x8255, 0x83AA, 0x8480 (sclk = clk/10) -> registers read F0, CC, 55, AA, 80 in address order; exactly 5 wr_strobe pulses; wr_addr 0..4; each value appears 4 cycles after ncs rises.
- Rejected frames:
  - read frame 0x00FF -> no register change, no strobe;
  - address 0x05 frame 0x85FF -> no change, no strobe;
  - address 0x7F frame 0xFF11 -> no change, no strobe.
- Bit-count errors: 15-bit frame, then 17-bit frame, each targeting address 0x04 with data 0x33 -> pwm_duty_cycle keeps its previous value; a following correct 0x8433 -> 0x33.
- Reset mid-frame: assert rst_n after 8 bits of 0x8177, release while ncs is still low, finish the frame -> en_reg_out_15_8 = 0x00, no strobe; next full 0x8177 -> 0x77.
- Back-to-back: two frames 0x8401, 0x84FE with minimum ncs high gap -> pwm_duty_cycle 0x01 then 0xFE; two strobes, each exactly 1 cycle wide.
